eng_uc_collector: RTL and testbench
===================================

ENG_UC_COLLECTOR -- requirements
Module: eng_uc_collector

Interface
REQ-001 Parameter NUM_ENGINE, default 4, number of solver engines.
REQ-002 Parameter UC_LENGTH, default 1024, literal space; LIT_W = clog2(UC_LENGTH) = 10.
REQ-003 Parameter QUIET_CYCLES, default 2, idle cycles before quiescent asserts.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 eng_valid  input  NUM_ENGINE  engine i presents a newly derived unit clause.
REQ-007 eng_uc  input  NUM_ENGINE x LIT_W  signed literal per engine, held stable while eng_valid[i] is high.
REQ-008 eng_busy  input  NUM_ENGINE  engine i is still propagating.
REQ-009 col2eng_ack  output  NUM_ENGINE  one-hot combinational pop, engine i's literal taken this cycle.
REQ-010 col2uca_valid  output  1  output literal register occupied.
REQ-011 col2uca  output  LIT_W  signed literal to the unit-clause arbiter.
REQ-012 col2uca_empty  output  1  high when col2uca_valid is low and all eng_valid are low.
REQ-013 uca_ready  input  1  downstream consumes col2uca this cycle when col2uca_valid is high.
REQ-014 quiescent  output  1  propagation round finished, no unit clauses pending anywhere.

Function
REQ-015 Slot free = !col2uca_valid | uca_ready; a grant occurs only when the slot is free and at least one eng_valid bit is set.
REQ-016 Grant target = first set eng_valid index at or after rr_ptr, searching upward modulo NUM_ENGINE; col2eng_ack is one-hot for that index, otherwise zero.
REQ-017 On a grant, col2uca <= eng_uc[grant], col2uca_valid <= 1, rr_ptr <= (grant+1) mod NUM_ENGINE at the same edge; latency eng_valid to col2uca_valid is 1 cycle.
REQ-018 Without a grant, uca_ready with col2uca_valid high clears col2uca_valid at the next edge; simultaneous drain and grant keeps col2uca_valid high with the new literal (back-to-back, one literal per cycle).
REQ-019 With col2uca_valid high and uca_ready low, col2uca is held unchanged and col2eng_ack is zero.
REQ-020 FSM states IDLE, XFER, QUIET, encoded in col_state_t.
REQ-021 IDLE->XFER on grant; XFER->IDLE when drained without a new grant; IDLE->QUIET when quiet_cnt reaches QUIET_CYCLES; QUIET->XFER on grant; QUIET->IDLE on any eng_busy bit without eng_valid.
REQ-022 quiet_cnt increments while eng_valid, eng_busy and col2uca_valid are all zero, saturates at QUIET_CYCLES, and clears otherwise.
REQ-023 quiescent = (state == QUIET); it drops at the edge on which any eng_valid or eng_busy bit is sampled high.
REQ-024 rr_ptr is a clog2(NUM_ENGINE)-bit counter that wraps from NUM_ENGINE-1 to 0.

Reset
REQ-025 Asserting rst forces state IDLE, rr_ptr 0, quiet_cnt 0, col2uca 0, col2uca_valid 0 and quiescent 0 immediately, regardless of clk.
REQ-026 A literal held in the output register when reset asserts is discarded and is not re-presented.
REQ-027 col2eng_ack is zero while rst is asserted.

Configuration
REQ-028 Macro UC_COLLECT_DEDUP_EN, when defined, adds a last-forwarded literal register and valid flag, both cleared by reset.
REQ-029 With UC_COLLECT_DEDUP_EN defined, a granted literal equal to the last forwarded literal is acked but not loaded, and rr_ptr still advances.
REQ-030 With UC_COLLECT_DEDUP_EN undefined, every granted literal is forwarded and no dedup logic is present.

Structure
REQ-031 Shared package uc_pkg holds NUM_ENGINE, UC_LENGTH, LIT_W, lit_t (signed LIT_W) and col_state_t.
REQ-032 Sub-module rr_pick holds the combinational round-robin priority search; it takes req and ptr and returns a one-hot grant and the grant index.

Verification
REQ-033 eng_valid=4'b1111, uca_ready=1 held, rr_ptr=0 -> acks 0,1,2,3,0, one per cycle; col2uca follows eng_uc in that order.
REQ-034 eng_valid[2]=1, eng_uc[2]=-5, uca_ready=0 for 3 cycles -> col2uca=-5 held, valid high, acks zero; uca_ready=1 -> drains and valid falls on the next edge.
REQ-035 rr_ptr=3, eng_valid=4'b1001 -> ack[3] first, then ack[0]; rr_ptr ends at 1.
REQ-036 All inputs low, QUIET_CYCLES=2 -> quiescent rises after 2 idle cycles; eng_busy[1] pulse -> quiescent falls on the next edge.
REQ-037 rst asserted mid-cycle with col2uca_valid=1 -> outputs clear immediately without clk; after release, the first grant comes from engine 0.
REQ-038 UC_COLLECT_DEDUP_EN defined, engine 1 sends +7 twice -> two acks, one forwarded +7; undefined -> two forwarded.

Source files
------------

// File: rtl/eng_uc_collector_pkg.sv
// Shared types and default sizing for the unit-clause collector slice.
package uc_pkg;

  localparam int unsigned NUM_ENGINE = 4;
  localparam int unsigned UC_LENGTH  = 1024;
  localparam int unsigned LIT_W      = $clog2(UC_LENGTH);

  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    QUIET = 2'd2
  } col_state_t;

endpackage

// File: rtl/eng_uc_collector_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, wrapping upward.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] gnt_idx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/eng_uc_collector.sv
// Collects unit clauses from solver engines into one output register, round-robin.
// Optional UC_COLLECT_DEDUP_EN suppresses a literal equal to the last one forwarded.
module eng_uc_collector #(
  parameter  int unsigned NUM_ENGINE   = uc_pkg::NUM_ENGINE,
  parameter  int unsigned UC_LENGTH    = uc_pkg::UC_LENGTH,
  parameter  int unsigned QUIET_CYCLES = 2,
  localparam int unsigned LIT_W        = $clog2(UC_LENGTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_ENGINE-1:0]               eng_valid,
  input  logic [NUM_ENGINE-1:0][LIT_W-1:0]    eng_uc,
  input  logic [NUM_ENGINE-1:0]               eng_busy,
  output logic [NUM_ENGINE-1:0]               col2eng_ack,
  output logic                                col2uca_valid,
  output logic signed [LIT_W-1:0]             col2uca,
  output logic                                col2uca_empty,
  input  logic                                uca_ready,
  output logic                                quiescent
);

  import uc_pkg::*;

  localparam int unsigned   PW   = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int unsigned   QW   = $clog2(QUIET_CYCLES + 2);
  localparam logic [QW-1:0] QMAX = QW'(QUIET_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(NUM_ENGINE - 1);

  col_state_t       state_q;
  logic             quiescent_q;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [QW-1:0]    quiet_cnt_q, quiet_cnt_d;
  logic [LIT_W-1:0] lit_q, lit_d;
  logic             lit_vld_q, lit_vld_d;

  logic [NUM_ENGINE-1:0] gnt_oh;
  logic [PW-1:0]         gnt_idx;
  logic [LIT_W-1:0]      sel_lit;
  logic                  slot_free, grant, load, dup, idle;

  rr_pick #(.N(NUM_ENGINE)) u_rr_pick (
    .req     (eng_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign slot_free = !lit_vld_q || uca_ready;
  assign grant     = slot_free && (|eng_valid);
  assign sel_lit   = eng_uc[gnt_idx];
  assign load      = grant && !dup;
  assign idle      = !(|eng_valid) && !(|eng_busy) && !lit_vld_q;

`ifdef UC_COLLECT_DEDUP_EN
  logic [LIT_W-1:0] last_q;
  logic             last_vld_q;

  assign dup = last_vld_q && (sel_lit == last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (load) begin
      last_q     <= sel_lit;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    lit_d       = load ? sel_lit : lit_q;
    lit_vld_d   = load ? 1'b1 : (uca_ready ? 1'b0 : lit_vld_q);
    rr_ptr_d    = rr_ptr_q;
    if (grant) rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
    quiet_cnt_d = '0;
    if (idle) quiet_cnt_d = (quiet_cnt_q == QMAX) ? QMAX : quiet_cnt_q + QW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lit_q       <= '0;
      lit_vld_q   <= 1'b0;
      rr_ptr_q    <= '0;
      quiet_cnt_q <= '0;
    end else begin
      lit_q       <= lit_d;
      lit_vld_q   <= lit_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

  // quiescent is registered alongside the state so it tracks (state == QUIET) exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      quiescent_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q     <= XFER;
            quiescent_q <= 1'b0;
          end else if (idle && quiet_cnt_d == QMAX) begin
            state_q     <= QUIET;
            quiescent_q <= 1'b1;
          end
        end
        XFER: begin
          if (!grant && !lit_vld_d) begin
            state_q     <= IDLE;
            quiescent_q <= 1'b0;
          end
        end
        QUIET: begin
          if (grant) begin
            state_q     <= XFER;
            quiescent_q <= 1'b0;
          end else if (|eng_busy) begin
            state_q     <= IDLE;
            quiescent_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          quiescent_q <= 1'b0;
        end
      endcase
    end
  end

  assign col2eng_ack   = (grant && rst) ? gnt_oh : '0;
  assign col2uca_valid = lit_vld_q;
  assign col2uca       = lit_q;
  assign col2uca_empty = !lit_vld_q && !(|eng_valid);
  assign quiescent     = quiescent_q;

endmodule

// File: tb/tb_eng_uc_collector.sv
// Scoreboard bench for eng_uc_collector: directed stimulus pushes expected acks/literals, a monitor pops them.
module tb_eng_uc_collector;
  import uc_pkg::*;

  logic             clk;
  logic             rst;
  logic [3:0]       eng_valid;
  logic [3:0][9:0]  eng_uc;
  logic [3:0]       eng_busy;
  logic [3:0]       col2eng_ack;
  logic             col2uca_valid;
  logic signed [9:0] col2uca;
  logic             col2uca_empty;
  logic             uca_ready;
  logic             quiescent;

  int vectors;
  int errs;
  logic [3:0] exp_ack_q[$];
  lit_t       exp_lit_q[$];

  eng_uc_collector #(
    .NUM_ENGINE   (4),
    .UC_LENGTH    (1024),
    .QUIET_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .eng_valid     (eng_valid),
    .eng_uc        (eng_uc),
    .eng_busy      (eng_busy),
    .col2eng_ack   (col2eng_ack),
    .col2uca_valid (col2uca_valid),
    .col2uca       (col2uca),
    .col2uca_empty (col2uca_empty),
    .uca_ready     (uca_ready),
    .quiescent     (quiescent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int idx, input int lit, input bit fwd);
    lit_t l;
    exp_ack_q.push_back(4'(1 << idx));
    l = lit_t'(lit);
    if (fwd) exp_lit_q.push_back(l);
  endtask

  initial begin
    vectors   = 0;
    errs      = 0;
    rst       = 1'b1;
    eng_valid = '0;
    eng_uc    = '0;
    eng_busy  = '0;
    uca_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (col2eng_ack != '0) begin
            if (exp_ack_q.size() == 0) chk("unexpected_ack", int'(col2eng_ack), 0);
            else chk("ack", int'(col2eng_ack), int'(exp_ack_q.pop_front()));
          end
          if (col2uca_valid && uca_ready) begin
            if (exp_lit_q.size() == 0) chk("unexpected_lit", int'(col2uca), -9999);
            else chk("lit", int'(col2uca), int'(exp_lit_q.pop_front()));
          end
        end
      end
    join_none

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", int'(col2uca_valid), 0);
    chk("rst_lit", int'(col2uca), 0);
    chk("rst_quiescent", int'(quiescent), 0);
    chk("rst_empty", int'(col2uca_empty), 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;

    // quiescence after two idle cycles, dropped by a busy pulse
    tick(1);
    chk("quiet_cnt1", int'(quiescent), 0);
    tick(1);
    chk("quiet_cnt2", int'(quiescent), 1);
    eng_busy = 4'b0010;
    tick(1);
    chk("quiet_busy_drop", int'(quiescent), 0);
    eng_busy = '0;

    // all engines valid, round-robin from 0
    uca_ready = 1'b1;
    eng_uc    = {10'(-44), 10'(33), 10'(-22), 10'(11)};
    eng_valid = 4'b1111;
    exp_grant(0, 11, 1);
    exp_grant(1, -22, 1);
    exp_grant(2, 33, 1);
    exp_grant(3, -44, 1);
    exp_grant(0, 11, 1);
    tick(1);
    chk("latency_valid", int'(col2uca_valid), 1);
    chk("rr_quiescent", int'(quiescent), 0);
    tick(4);
    eng_valid = '0;
    tick(2);
    chk("rr_drained", int'(col2uca_valid), 0);

    // backpressure hold on engine 2, then back-to-back drain+grant
    uca_ready = 1'b0;
    eng_uc[2] = 10'(-5);
    eng_valid = 4'b0100;
    exp_grant(2, -5, 1);
    tick(1);
    eng_uc[2] = 10'(-6);
    exp_grant(2, -6, 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", int'(col2uca_valid), 1);
      chk("hold_lit", int'(col2uca), -5);
      chk("hold_ack", int'(col2eng_ack), 0);
      if (i == 0) chk("hold_empty", int'(col2uca_empty), 0);
      tick(1);
    end
    uca_ready = 1'b1;
    tick(1);
    eng_valid = '0;
    chk("b2b_valid", int'(col2uca_valid), 1);
    chk("b2b_lit", int'(col2uca), -6);
    tick(1);
    chk("drain_valid", int'(col2uca_valid), 0);
    chk("drain_empty", int'(col2uca_empty), 1);

    // pointer at 3: 1001 grants 3 then 0, pointer then at 1
    eng_uc    = {10'(100), 10'(0), 10'(0), 10'(-100)};
    eng_valid = 4'b1001;
    exp_grant(3, 100, 1);
    exp_grant(0, -100, 1);
    tick(1);
    eng_valid = 4'b0001;
    tick(1);
    eng_valid = '0;
    tick(1);
    eng_uc    = {10'(0), 10'(0), 10'(2), 10'(1)};
    eng_valid = 4'b0011;
    exp_grant(1, 2, 1);
    exp_grant(0, 1, 1);
    tick(1);
    eng_valid = 4'b0001;
    tick(1);
    eng_valid = '0;
    tick(1);

    // reset mid-cycle while a literal is held; it must be dropped
    uca_ready = 1'b0;
    eng_uc[1] = 10'(55);
    eng_valid = 4'b0010;
    exp_grant(1, 55, 0);
    tick(1);
    chk("pre_rst_valid", int'(col2uca_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(col2uca_valid), 0);
    chk("async_rst_lit", int'(col2uca), 0);
    chk("async_rst_ack", int'(col2eng_ack), 0);
    chk("async_rst_quiescent", int'(quiescent), 0);
    eng_valid = '0;
    uca_ready = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    tick(1);
    eng_uc    = {10'(24), 10'(23), 10'(22), 10'(21)};
    eng_valid = 4'b1111;
    exp_grant(0, 21, 1);
    tick(1);
    eng_valid = '0;
    tick(2);

    // engine 1 sends +7 twice
    eng_uc[1] = 10'(7);
    eng_valid = 4'b0010;
    exp_grant(1, 7, 1);
    tick(1);
`ifdef UC_COLLECT_DEDUP_EN
    exp_grant(1, 7, 0);
`else
    exp_grant(1, 7, 1);
`endif
    tick(1);
    eng_valid = '0;
    tick(3);

    chk("ack_queue_empty", exp_ack_q.size(), 0);
    chk("lit_queue_empty", exp_lit_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
